fp_add_normalizer: RTL

Normalize-and-round stage of the FP add/sub datapath. It sits directly downstream of the mantissa adder, which sums the two aligned, conditionally inverted mantissae produced by the mantissa adjuster. It takes the sum magnitude, its sign and the larger operand exponent, normalizes iteratively (one bit per cycle), rounds to nearest-even and emits a packed sign/exponent/fraction result over a valid/ready handshake.

---
 rtl/fp_add_normalizer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fp_add_normalizer.sv
// Normalize-and-round stage behind the FP mantissa adder: iterative one-bit-per-cycle
// normalization, round-to-nearest-even on the carry-shift guard bit, packed result out.
module fp_add_normalizer #(
  parameter int DATA_WIDTH = 52,
  parameter int EXP_WIDTH  = 11
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  input  logic [DATA_WIDTH+1:0] in_mag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [DATA_WIDTH-1:0] out_mant,
  output logic                  out_overflow,
  output logic                  out_underflow,
  output logic [1:0]            dbgState
);

  localparam int MW = DATA_WIDTH + 2;
  localparam int EW = EXP_WIDTH + 1;
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_SAT = {1'b0, {EXP_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [MW-1:0] magReg, magNext;
  logic [EW-1:0] expReg, expNext;
  logic          signReg, signNext;
  logic          rbitReg, rbitNext;

  logic                  outValidNext;
  logic                  outSignNext;
  logic [EXP_WIDTH-1:0]  outExpNext;
  logic [DATA_WIDTH-1:0] outMantNext;
  logic                  outOverflowNext;
  logic                  outUnderflowNext;

  logic [MW-1:0]         roundedMag;
  logic                  roundCarry;
  logic [DATA_WIDTH-1:0] roundFrac;
  logic [EW-1:0]         roundExp;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds with all
  // out_* stable until out_ready, then drops on the following cycle.
  assign in_ready = (state == IDLE);
  assign dbgState = state;

  // The only guard bit is the one shifted out by a carry; no sticky, so rbit && lsb is ties-to-even.
  always_comb begin
    roundedMag = magReg + {{(MW-1){1'b0}}, rbitReg & magReg[0]};
    roundCarry = roundedMag[MW-1];
    roundFrac  = roundCarry ? roundedMag[DATA_WIDTH:1] : roundedMag[DATA_WIDTH-1:0];
    roundExp   = roundCarry ? expReg + EXP_ONE : expReg;
  end

  always_comb begin
    stateNext        = state;
    magNext          = magReg;
    expNext          = expReg;
    signNext         = signReg;
    rbitNext         = rbitReg;
    outValidNext     = out_valid;
    outSignNext      = out_sign;
    outExpNext       = out_exp;
    outMantNext      = out_mant;
    outOverflowNext  = out_overflow;
    outUnderflowNext = out_underflow;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          magNext          = in_mag;
          expNext          = {1'b0, in_exp};
          signNext         = in_sign;
          rbitNext         = 1'b0;
          outOverflowNext  = 1'b0;
          outUnderflowNext = 1'b0;
          stateNext        = NORM;
        end
      end

      NORM: begin
        if (magReg == '0) begin
          outSignNext  = 1'b0;
          outExpNext   = '0;
          outMantNext  = '0;
          outValidNext = 1'b1;
          stateNext    = DONE;
        end else if (magReg[DATA_WIDTH+1]) begin
          rbitNext  = magReg[0];
          magNext   = magReg >> 1;
          expNext   = expReg + EXP_ONE;
          stateNext = ROUND;
        end else if (magReg[DATA_WIDTH]) begin
          stateNext = ROUND;
        end else if (expReg <= EXP_ONE) begin
          // Cannot shift further without dropping below the smallest normal exponent.
          outSignNext      = 1'b0;
          outExpNext       = '0;
          outMantNext      = '0;
          outUnderflowNext = 1'b1;
          outValidNext     = 1'b1;
          stateNext        = DONE;
        end else begin
          magNext = magReg << 1;
          expNext = expReg - EXP_ONE;
        end
      end

      ROUND: begin
        outSignNext  = signReg;
        outValidNext = 1'b1;
        if (roundExp >= EXP_SAT) begin
          outExpNext      = {EXP_WIDTH{1'b1}};
          outMantNext     = '0;
          outOverflowNext = 1'b1;
        end else begin
          outExpNext  = roundExp[EXP_WIDTH-1:0];
          outMantNext = roundFrac;
        end
        stateNext = DONE;
      end

      DONE: begin
        if (out_ready) begin
          outValidNext = 1'b0;
          stateNext    = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state         <= IDLE;
      magReg        <= '0;
      expReg        <= '0;
      signReg       <= 1'b0;
      rbitReg       <= 1'b0;
      out_valid     <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_mant      <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      state         <= stateNext;
      magReg        <= magNext;
      expReg        <= expNext;
      signReg       <= signNext;
      rbitReg       <= rbitNext;
      out_valid     <= outValidNext;
      out_sign      <= outSignNext;
      out_exp       <= outExpNext;
      out_mant      <= outMantNext;
      out_overflow  <= outOverflowNext;
      out_underflow <= outUnderflowNext;
    end
  end

endmodule
